// File: rtl/max_func_arbiter.sv
// max_func_arbiter
// ----------------
// Shares one max_func instance between NUMREQ requesters. A round-robin
// arbiter picks one requester in IDLE, the winning packed vector is latched
// and presented to max_func with a one-cycle ip_valid pulse, and the result is
// returned to the granted requester as a one-cycle one-hot rsp_valid strobe.
// Only one transaction is outstanding at a time.
//
// Handshake semantics: a requester raises req_valid[i] with its slice of
// req_data and holds both stable until it sees req_ready[i]=1 (combinational,
// IDLE only); the transfer happens on that rising edge and the requester may
// drop req_valid from the next cycle. Responses have no backpressure: the
// requester must sample rsp_data/rsp_err when rsp_valid[i]=1.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   per-requester request / one-hot accept
//   req_data          packed vectors, requester i occupies slice i
//   rsp_valid         one-hot result strobe
//   rsp_data/rsp_err  result and timeout flag, qualified by rsp_valid
//   mf_ip_data/valid  to max_func
//   mf_op_data/valid  from max_func
//   busy              high whenever the FSM is not in IDLE
//   dbg_state         current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//
// Optional feature: define MAX_ARB_TIMEOUT_EN to enable a watchdog in WAIT
// that answers with rsp_data=0, rsp_err=1 after TIMEOUT_CYCLES WAIT cycles.

module max_func_arbiter #(
  parameter int NUMREQ         = 4,
  parameter int NUMINPUT       = 10,
  parameter int INPUTWIDTH     = 16,
  parameter int OPDATA_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUMREQ-1:0]                      req_valid,
  input  logic [NUMREQ*NUMINPUT*INPUTWIDTH-1:0]  req_data,
  output logic [NUMREQ-1:0]                      req_ready,
  output logic [NUMREQ-1:0]                      rsp_valid,
  output logic [OPDATA_WIDTH-1:0]                rsp_data,
  output logic                                   rsp_err,
  output logic [NUMINPUT*INPUTWIDTH-1:0]         mf_ip_data,
  output logic                                   mf_ip_valid,
  input  logic [OPDATA_WIDTH-1:0]                mf_op_data,
  input  logic                                   mf_op_data_valid,
  output logic                                   busy,
  output logic [1:0]                             dbg_state
);

  localparam int VW = NUMINPUT * INPUTWIDTH;
  localparam int GW = (NUMREQ > 1) ? $clog2(NUMREQ) : 1;

  // Elaboration-time sanity check on the parameter set; the block is empty
  // and only exists so an illegal configuration is visible in the hierarchy.
  if (NUMREQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check_invalid
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [VW-1:0]           ip_data_q, ip_data_d;
  logic [OPDATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;

  // Round-robin search starting just after the last grant.
  logic          grant_vld;
  logic [GW-1:0] grant_idx;
  logic [GW-1:0] cand_idx;
  logic [VW-1:0] sel_data;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NUMREQ; k++) begin
      cand_idx = GW'((int'(last_grant_q) + k) % NUMREQ);
      if (!grant_vld && req_valid[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUMREQ; i++) begin
      if (GW'(i) == grant_idx) begin
        sel_data = req_data[i*VW +: VW];
      end
    end
  end

`ifdef MAX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // cnt_q holds the number of WAIT cycles already completed, so the cycle in
  // which it equals TIMEOUT_CYCLES-1 is the last permitted WAIT cycle.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    ip_data_d    = ip_data_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
`ifdef MAX_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          ip_data_d    = sel_data;
          grant_d      = grant_idx;
          last_grant_d = grant_idx;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
`ifdef MAX_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving in the timeout cycle takes precedence.
        if (mf_op_data_valid) begin
          rsp_data_d = mf_op_data;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end
`ifdef MAX_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUMREQ - 1);
      grant_q      <= '0;
      ip_data_q    <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
`ifdef MAX_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      ip_data_q    <= ip_data_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
`ifdef MAX_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign req_ready   = (state_q == IDLE && grant_vld) ? (NUMREQ'(1) << grant_idx) : '0;
  assign rsp_valid   = (state_q == RESP) ? (NUMREQ'(1) << grant_q) : '0;
  assign rsp_data    = rsp_data_q;
  assign mf_ip_data  = ip_data_q;
  assign mf_ip_valid = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

`ifdef MAX_ARB_TIMEOUT_EN
  assign rsp_err = (state_q == RESP) & rsp_err_q;
`else
  assign rsp_err = 1'b0;
  logic unused_err;
  assign unused_err = rsp_err_q;
`endif

endmodule

// File: doc/max_func_arbiter.md
Name: max_func_arbiter

Overview:
Shares one max_func instance between NUMREQ requesters, such as parallel pooling windows or channel lanes. It arbitrates round-robin, latches the winning request's packed vector, and drives max_func with a single-cycle ip_valid pulse. It then waits for op_data_valid and returns the result to the granted requester. Only one transaction is outstanding at a time; the block sits between the pooling/window-gather stage and the shared max_func.

Parameters:
NUMREQ, 4, number of requesters (≥2)
NUMINPUT, 10, elements per request vector (matches max_func)
INPUTWIDTH, 16, bits per element (matches max_func)
OPDATA_WIDTH, 32, max_func result width
TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with MAX_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NUMREQ  per-requester request
req_data  in  NUMREQ*NUMINPUT*INPUTWIDTH  packed vectors; requester i occupies slice i
req_ready  out  NUMREQ  one-hot accept
rsp_valid  out  NUMREQ  one-hot result strobe
rsp_data  out  OPDATA_WIDTH  result
rsp_err  out  1  timeout flag, qualified by rsp_valid
mf_ip_data  out  NUMINPUT*INPUTWIDTH  to max_func ip_data
mf_ip_valid  out  1  to max_func ip_valid
mf_op_data  in  OPDATA_WIDTH  from max_func op_data
mf_op_data_valid  in  1  from max_func op_data_valid
busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-low, port rst_n, sampled on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - state=IDLE; every output and data register = 0.
  - last_grant=NUMREQ-1, so requester 0 has top priority first.
  - Reset in any state abandons the transaction, with no rsp_valid.
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - grant = first asserted req_valid searching last_grant+1, +2, … modulo NUMREQ.
  - req_ready[grant] = 1, combinational, only in IDLE; no requester valid → req_ready=0.
  - At the edge: latch req_data slice and grant index; last_grant ← grant; go to ISSUE.
  - Requester must hold req_valid and data stable until req_ready=1 and may drop them the cycle after.
- ISSUE:
  - mf_ip_valid=1 for exactly this cycle; mf_ip_data = latched vector.
  - mf_ip_data holds the latched vector until the next accept.
  - Next state WAIT.
- WAIT:
  - mf_op_data_valid=1 → capture mf_op_data; go to RESP.
  - mf_op_data_valid is ignored in IDLE, ISSUE and RESP (stray or late pulses are dropped).
- RESP:
  - rsp_valid[granted]=1 for exactly one cycle; rsp_data = captured value; rsp_err=0 unless timed out.
  - No response backpressure; requester must sample.
  - Next state IDLE.
  - rsp_data holds until the next RESP; rsp_valid=0 elsewhere.
- Latency and throughput:
  - Accept edge to mf_ip_valid: 1 cycle.
  - mf_op_data_valid edge to rsp_valid: 1 cycle.
  - Minimum spacing between accepts: 3 + max_func latency.
- Simultaneous events: a requester whose rsp_valid is high may also be eligible for req_ready in the following IDLE cycle, subject to round-robin order.
- Width rule: rsp_data passes through unmodified; no sign handling.

Optional Feature:
Macro: MAX_ARB_TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TIMEOUT_CYCLES+1) clears on WAIT entry and increments each WAIT cycle.
  - Counter reaching TIMEOUT_CYCLES without mf_op_data_valid → go to RESP with rsp_data=0, rsp_err=1.
  - mf_op_data_valid in the same cycle as the timeout wins; rsp_err=0.
- Undefined: no counter; WAIT persists indefinitely; rsp_err tied 0.

Test Plan:
Bench uses a max_func model that returns the unsigned lane max 5 cycles after ip_valid.
1. Single request: req_valid=4'b0010, slice1=hF5F5_F9F9_AAAA_5555_5555_5555 → req_ready=4'b0010 one cycle; mf_ip_valid one pulse next cycle with the same data; rsp_valid=4'b0010 with rsp_data=32'h0000_F9F9 one cycle after mf_op_data_valid; busy falls with IDLE.
2. All four requesters held high, then data hAAAA_BBBB_F5F5_DDDD_AAAA_5555_5555_5555 on all → grants 0,1,2,3,0 in order; each rsp_valid one-hot matches its grant; rsp_data=32'h0000_F5F5.
3. After grant to requester 2, requesters 0 and 3 request together → 3 granted before 0.
4. Stray mf_op_data_valid pulse in IDLE and in ISSUE → no rsp_valid, state unchanged.
5. rst_n=0 for one cycle during WAIT → all outputs 0 the next cycle; the late model response is ignored; the next request from 0 and 1 together grants 0.
6. MAX_ARB_TIMEOUT_EN defined, model silent → rsp_valid with rsp_err=1, rsp_data=0 after 64 WAIT cycles. Macro undefined, same stimulus → busy stays 1 for 1000 cycles with no rsp_valid.
